scene_recovery_te: RTL and testbench

- Inverse end of the transmission-estimation path. Consumes the per-pixel transmission T(x) in Q0.16 and the hazy pixel I(x), with atmospheric light A per channel.
- Recovers scene radiance J = (I − A) / max(T, T0) + A for R, G and B.
- Sits after the transmission subtractor/refinement stage and before pixel output.
- Fully pipelined at one pixel per clock, with a valid/ready stall.

---
 rtl/haze_pkg.sv | 30 +++
 rtl/scene_recovery_te_if.sv | 35 +++
 rtl/recip_rom_te.sv | 23 ++
 rtl/scene_recovery_te.sv | 101 ++++++++++
 tb/tb_scene_recovery_te.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/haze_pkg.sv
// Constants, types and ROM-content helper shared by the haze-removal
// blocks: the TE subtractor and scene recovery.
package haze_pkg;

  localparam int PIX_W      = 8;
  localparam int T_W        = 16;
  localparam int LUT_ADDR_W = 8;
  localparam int RECIP_FRAC = 14;
  localparam int RECIP_W    = 16;
  localparam int DIFF_W     = PIX_W + 1;          // I - A, signed -255..255
  localparam int PROD_W     = 25;                 // d * recip, signed
  localparam int SUM_W      = 12;                 // q + A, signed

  localparam logic [T_W-1:0] T0  = 16'd21299;     // 0.325 in Q0.16
  localparam logic [T_W-1:0] ONE = 16'd65535;

  // The first ROM entry that a clamped transmission can address
  localparam int RECIP_K_MIN = int'(T0 >> (T_W - LUT_ADDR_W));

  // Reciprocal of the bucket centre, Q2.14. Addresses below the clamp
  // bound can never be reached, so they hold the first reachable value.
  function automatic logic [RECIP_W-1:0] recip_entry(input int k);
    longint unsigned kk;
    longint unsigned den;
    kk  = (k < RECIP_K_MIN) ? longint'(RECIP_K_MIN) : longint'(k);
    den = kk * 256 + 128;
    return RECIP_W'((64'd1 << 30) / den);
  endfunction

endpackage

// File: rtl/scene_recovery_te_if.sv
// Pixel bus for the scene-recovery stage.
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A producer may change data only after a transfer or while valid is low;
// a stalled output (valid && !ready) keeps valid and data stable.
interface scene_recovery_te_if;
  import haze_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [T_W-1:0]   in_t;
  logic [PIX_W-1:0] in_r;
  logic [PIX_W-1:0] in_g;
  logic [PIX_W-1:0] in_b;
  logic [PIX_W-1:0] a_r;
  logic [PIX_W-1:0] a_g;
  logic [PIX_W-1:0] a_b;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_r;
  logic [PIX_W-1:0] out_g;
  logic [PIX_W-1:0] out_b;

  // Producer/consumer side of the block (testbench or neighbouring stages)
  modport master (
    output in_valid, in_t, in_r, in_g, in_b, a_r, a_g, a_b, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b
  );

  // The recovery block itself
  modport slave (
    input  in_valid, in_t, in_r, in_g, in_b, a_r, a_g, a_b, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b
  );

endinterface

// File: rtl/recip_rom_te.sv
// 256 x 16 reciprocal ROM, registered output, holds when en is low.
module recip_rom_te
  import haze_pkg::*;
(
  input  logic                  clk,
  input  logic                  en,
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [RECIP_W-1:0]    data
);

  logic [RECIP_W-1:0] rom [2**LUT_ADDR_W];

  // Contents are elaboration-time constants from the reciprocal formula
  for (genvar k = 0; k < 2**LUT_ADDR_W; k++) begin : g_rom
    assign rom[k] = recip_entry(k);
  end

  // Synchronous read, frozen together with the rest of the pipeline
  always_ff @(posedge clk) begin
    if (en) data <= rom[addr];
  end

endmodule

// File: rtl/scene_recovery_te.sv
// Scene radiance recovery: J = (I - A) / max(T, T0) + A per channel.
// Four-stage pipeline, one pixel per clock, global stall on out_ready.
module scene_recovery_te
  import haze_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  scene_recovery_te_if.slave bus
);

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  logic [PIX_W-1:0] a_v [3];
  logic [PIX_W-1:0] i_v [3];
  assign a_v[0] = bus.a_r;
  assign a_v[1] = bus.a_g;
  assign a_v[2] = bus.a_b;
  assign i_v[0] = bus.in_r;
  assign i_v[1] = bus.in_g;
  assign i_v[2] = bus.in_b;

  // ROM address of the clamped transmission; below T0 it is T0's bucket
  logic [LUT_ADDR_W-1:0] addr_c;
  assign addr_c = (bus.in_t < T0) ? T0[T_W-1 -: LUT_ADDR_W]
                                  : bus.in_t[T_W-1 -: LUT_ADDR_W];

  logic                     v1, v2, v3, v4;
  logic [LUT_ADDR_W-1:0]    addr1;
  logic [PIX_W-1:0]         i1 [3];
  logic signed [DIFF_W-1:0] d2 [3];
  logic [RECIP_W-1:0]       recip2;
  logic signed [PROD_W-1:0] p3 [3];
  logic [PIX_W-1:0]         o4 [3];
  logic signed [SUM_W-1:0]  j_c [3];
  logic [PIX_W-1:0]         sat_c [3];

  // Stage valid flags: bubbles travel as zeros, reset flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
    end
  end

  // Stages 1-3 datapath: capture, difference, multiply by reciprocal
  always_ff @(posedge clk) begin
    if (adv) begin
      addr1 <= addr_c;
      for (int c = 0; c < 3; c++) begin
        i1[c] <= i_v[c];
        d2[c] <= $signed({1'b0, i1[c]}) - $signed({1'b0, a_v[c]});
        p3[c] <= PROD_W'($signed(d2[c]) * $signed({1'b0, recip2}));
      end
    end
  end

  recip_rom_te u_recip_rom (
    .clk  (clk),
    .en   (adv),
    .addr (addr1),
    .data (recip2)
  );

  // Stage 4 combinational: round, shift back to pixel scale, add A, clamp
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      j_c[c] = SUM_W'((p3[c] + 25'sd8192) >>> RECIP_FRAC)
             + $signed({4'b0000, a_v[c]});
      if (j_c[c] < 0)
        sat_c[c] = '0;
      else if (j_c[c] > 12'sd255)
        sat_c[c] = 8'd255;
      else
        sat_c[c] = j_c[c][PIX_W-1:0];
    end
  end

  // Output register: cleared by reset, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) o4[c] <= '0;
    end else if (adv) begin
      for (int c = 0; c < 3; c++) o4[c] <= sat_c[c];
    end
  end

  assign bus.out_valid = v4;
  assign bus.out_r     = o4[0];
  assign bus.out_g     = o4[1];
  assign bus.out_b     = o4[2];

endmodule

// File: tb/tb_scene_recovery_te.sv
// Self-checking bench for scene_recovery_te: directed cases, stall and
// reset scenarios, and a randomized run against a formula-level model.
module tb_scene_recovery_te;

  localparam int T0_I = 21299;

  logic clk;
  logic rst;

  scene_recovery_te_if bus ();

  scene_recovery_te dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [23:0] exp_q[$];
  int n_checks;
  int n_pass;
  int cyc;
  int first_out;
  int last_out;
  int n_out;
  bit last_accept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model straight from the recovery formula
  function automatic int recover_ch(input int t, input int i, input int a);
    int tc;
    longint recip;
    longint num;
    longint q;
    int j;
    tc    = (t < T0_I) ? T0_I : t;
    recip = (longint'(1) << 30) / ((tc / 256) * 256 + 128);
    num   = longint'(i - a) * recip + 8192;
    q     = (num >= 0) ? num / 16384 : -((-num + 16383) / 16384);
    j     = int'(q) + a;
    if (j < 0) j = 0;
    if (j > 255) j = 255;
    return j;
  endfunction

  function automatic logic [23:0] model(input int t, input int r, input int g, input int b);
    int ar, ag, ab;
    ar = int'(bus.a_r);
    ag = int'(bus.a_g);
    ab = int'(bus.a_b);
    return {8'(recover_ch(t, r, ar)), 8'(recover_ch(t, g, ag)), 8'(recover_ch(t, b, ab))};
  endfunction

  // Driver tasks
  task automatic set_pixel(input logic [15:0] t, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b);
    bus.in_t = t;
    bus.in_r = r;
    bus.in_g = g;
    bus.in_b = b;
  endtask

  task automatic set_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.a_r = r;
    bus.a_g = g;
    bus.a_b = b;
  endtask

  // Evaluate handshakes just before the edge, then advance one cycle
  task automatic tick();
    #1;
    last_accept = 1'b0;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        check("out_data", {8'd0, bus.out_r, bus.out_g, bus.out_b}, {8'd0, exp_q[0]});
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
          n_out++;
        end else begin
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(int'(bus.in_t), int'(bus.in_r), int'(bus.in_g), int'(bus.in_b)));
      last_accept = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag);
    int k;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // One isolated pixel: latency and value against a hand-derived constant
  task automatic run_one(input string tag, input logic [15:0] t, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b, input logic [23:0] exp_rgb);
    int n;
    set_pixel(t, r, g, b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_rgb"}, {8'd0, bus.out_r, bus.out_g, bus.out_b}, {8'd0, exp_rgb});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  function automatic logic [15:0] rand_t();
    logic [15:0] edges [7];
    edges[0] = 16'd0;
    edges[1] = 16'(T0_I - 1);
    edges[2] = 16'(T0_I);
    edges[3] = 16'(T0_I + 1);
    edges[4] = 16'd65535;
    edges[5] = 16'd65280;
    edges[6] = 16'd255;
    if ($urandom_range(0, 7) == 0) return edges[$urandom_range(0, 6)];
    return 16'($urandom_range(0, 65535));
  endfunction

  initial begin
    int sent;
    int k;
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    first_out = -1;
    last_out = -1;
    n_out = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_pixel(16'd0, 8'd0, 8'd0, 8'd0);
    set_a(8'd200, 8'd200, 8'd200);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_rgb", {8'd0, bus.out_r, bus.out_g, bus.out_b}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Hand-derived directed cases
    run_one("unity_gain", 16'd65535, 8'd100, 8'd100, 8'd100, {8'd100, 8'd100, 8'd100});
    run_one("clamp_t0", 16'd1000, 8'd220, 8'd150, 8'd200, {8'd255, 8'd47, 8'd200});
    run_one("t_zero_i_eq_a", 16'd0, 8'd200, 8'd200, 8'd200, {8'd200, 8'd200, 8'd200});
    set_a(8'd10, 8'd128, 8'd250);
    run_one("sat_per_channel", 16'd1000, 8'd0, 8'd128, 8'd255, {8'd0, 8'd128, 8'd255});

    // 16 back-to-back pixels
    set_a(8'd180, 8'd60, 8'd120);
    cyc = 0; first_out = -1; last_out = -1; n_out = 0;
    for (int i = 0; i < 16; i++) begin
      set_pixel(rand_t(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)));
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      tick();
    end
    drain("stream16");
    check("stream16_first", 32'(first_out), 32'd4);
    check("stream16_last", 32'(last_out), 32'd19);
    check("stream16_count", 32'(n_out), 32'd16);

    // Stream with out_ready held low for five cycles
    sent = 0; k = 0; n_out = 0;
    set_pixel(rand_t(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)));
    while (sent < 12 && k < 60) begin
      bus.in_valid = 1'b1;
      bus.out_ready = !(k >= 5 && k < 10);
      tick();
      if (last_accept) begin
        sent++;
        set_pixel(rand_t(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
      end
      k++;
    end
    drain("stall");
    check("stall_count", 32'(n_out), 32'd12);

    // Reset with three pixels in flight
    for (int i = 0; i < 3; i++) begin
      set_pixel(rand_t(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)));
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_rgb", {8'd0, bus.out_r, bus.out_g, bus.out_b}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_ghost", 32'(bus.out_valid), 32'd0);
    end
    set_a(8'd200, 8'd200, 8'd200);
    run_one("after_reset", 16'd65535, 8'd100, 8'd100, 8'd100, {8'd100, 8'd100, 8'd100});

    // Randomized traffic, A changed only when the pipeline is empty
    for (int blk = 0; blk < 20; blk++) begin
      set_a(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      sent = 0; k = 0;
      while (sent < 500 && k < 3000) begin
        if ($urandom_range(0, 15) == 0)
          set_pixel(rand_t(), bus.a_r, bus.a_g, bus.a_b);
        else
          set_pixel(rand_t(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)));
        bus.in_valid  = ($urandom_range(0, 99) < 85);
        bus.out_ready = ($urandom_range(0, 99) < 80);
        tick();
        if (last_accept) sent++;
        k++;
      end
      check("rand_block_sent", 32'(sent), 32'd500);
      drain("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
